lsu_pipe: RTL and testbench

- Parametrised, handshaked successor to the single-cycle load/store unit.
- Decodes each request into data memory, output-peripheral registers or the input-peripheral port.
- Handles byte, half and word sizes with internal byte-enable generation and load sign/zero extension.
- Splits misaligned data-memory accesses into two word accesses under a small FSM; sits between the core's MEM stage and the memory/IO fabric.

---
 rtl/lsu_pipe_pkg.sv | 74 +++++++
 rtl/lsu_pipe_if.sv | 30 +++
 rtl/lsu_pipe_dmem.sv | 32 +++
 rtl/lsu_pipe.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pipe_pkg.sv
// lsu_pipe shared types and helpers.
// Size/region/state encodings plus byte-enable and load-extension helpers.
package lsu_pipe_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        REG_DMEM = 2'b00,
        REG_OUT  = 2'b01,
        REG_IN   = 2'b10
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Two-word byte enables: [3:0] for word N, [7:4] for word N+1.
    function automatic logic [7:0] be_gen(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] ld_ext(
        input logic [31:0] raw,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] r;
        case (size)
            SZ_B:    r = uns ? {24'h0, raw[7:0]}
                         : {{24{raw[7]}}, raw[7:0]};
            SZ_H:    r = uns ? {16'h0, raw[15:0]}
                         : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Not naturally aligned for its size.
    function automatic logic is_misal(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SZ_H && off[0])
            || (size == SZ_W && off != 2'b00);
    endfunction

    // Touches bytes beyond the current word.
    function automatic logic is_split(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SZ_H && off == 2'b11)
            || (size == SZ_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// lsu_pipe request/response bus.
// master = core MEM stage, slave = load/store unit.
interface lsu_pipe_if #(
    parameter int ADDR_W = 12
) ();

    logic              req_i;
    logic              ready_o;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [1:0]        size_i;
    logic              unsign_i;
    logic [31:0]       wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, size_i,
        output unsign_i, wdata_i,
        input  ready_o, rsp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, size_i,
        input  unsign_i, wdata_i,
        output ready_o, rsp_valid_o, rdata_o, err_o
    );

endinterface

// File: rtl/lsu_pipe_dmem.sv
// lsu_pipe data memory.
// Byte-enabled synchronous-read RAM; the array is never reset.
module lsu_dmem #(
    parameter int WORDS = 512,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read of the same word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: handshaked load/store unit.
// Decodes dmem/output/input regions and splits word-crossing dmem accesses.
module lsu_pipe
    import lsu_pipe_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DMEM_WORDS = 512,
    parameter int NUM_OUT    = 11
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    lsu_pipe_if.slave              bus,
    input  logic [31:0]            io_in_i,
    output logic [NUM_OUT*32-1:0]  io_out_o
);

    localparam int DW = $clog2(DMEM_WORDS);
    localparam int OW = ADDR_W - 6;

    state_e        state_q, state_d;
    logic          rdy_q;
    logic          acc;

    region_e       rg_in;
    logic          mis_in, bad_in, spl_in;

    logic          we_q;
    logic [1:0]    off_q;
    logic [DW-1:0] widx_q;
    logic [OW-1:0] oidx_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    region_e       reg_q;
    logic          bad_q;
    logic          split_q;

    logic [7:0]    be;
    logic [63:0]   wsh;

    logic          dm_we;
    logic [3:0]    dm_be;
    logic [DW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic [31:0]   lo_q;

    logic [31:0]   out_q [NUM_OUT];
    logic          out_wr;
    logic [31:0]   out_rd;
    logic [31:0]   io_in_q;

    logic [63:0]   src;
    logic [31:0]   raw;
    logic [31:0]   ld_val;

    logic          rsp_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    assign acc = bus.req_i && rdy_q;

    // Region, alignment and error decode of the incoming request.
    always_comb begin
        if (!bus.addr_i[ADDR_W-1]) begin
            rg_in = REG_DMEM;
        end else if (!bus.addr_i[ADDR_W-4]) begin
            rg_in = REG_OUT;
        end else begin
            rg_in = REG_IN;
        end
        mis_in = is_misal(bus.size_i, bus.addr_i[1:0]);
        bad_in = (bus.size_i == SZ_BAD)
              || (mis_in && rg_in != REG_DMEM);
        spl_in = (rg_in == REG_DMEM)
              && is_split(bus.size_i, bus.addr_i[1:0]);
    end

    // Capture every request field at acceptance.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            off_q   <= '0;
            widx_q  <= '0;
            oidx_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            reg_q   <= REG_DMEM;
            bad_q   <= 1'b0;
            split_q <= 1'b0;
        end else if (acc) begin
            we_q    <= bus.we_i;
            off_q   <= bus.addr_i[1:0];
            widx_q  <= bus.addr_i[DW+1:2];
            oidx_q  <= bus.addr_i[ADDR_W-5:2];
            size_q  <= bus.size_i;
            uns_q   <= bus.unsign_i;
            wdata_q <= bus.wdata_i;
            reg_q   <= rg_in;
            bad_q   <= bad_in;
            split_q <= spl_in;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (acc) state_d = ST_ACC0;
            ST_ACC0: state_d = split_q ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; ready is only raised once back in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    assign be  = be_gen(size_q, off_q);
    assign wsh = {32'h0, wdata_q} << {off_q, 3'b000};

    // Word N in ACC0, word N+1 (wrapping) in ACC1.
    always_comb begin
        dm_addr  = widx_q;
        dm_be    = be[3:0];
        dm_wdata = wsh[31:0];
        if (state_q == ST_ACC1) begin
            dm_addr  = widx_q + 1'b1;
            dm_be    = be[7:4];
            dm_wdata = wsh[63:32];
        end
        dm_we = rst_ni && we_q && !bad_q
             && (reg_q == REG_DMEM)
             && (state_q == ST_ACC0 || state_q == ST_ACC1);
    end

    lsu_dmem #(
        .WORDS (DMEM_WORDS),
        .AW    (DW)
    ) u_dmem (
        .clk_i   (clk_i),
        .we_i    (dm_we),
        .be_i    (dm_be),
        .addr_i  (dm_addr),
        .wdata_i (dm_wdata),
        .rdata_o (dm_rdata)
    );

    // Hold the low word of a split load while the high word is read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lo_q <= '0;
        end else if (state_q == ST_ACC1) begin
            lo_q <= dm_rdata;
        end
    end

    assign out_wr = (state_q == ST_ACC0) && we_q && !bad_q
                 && (reg_q == REG_OUT);

    // Output registers, byte-enabled; out-of-range indices match nothing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else if (out_wr) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (oidx_q == OW'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            out_q[k][8*b +: 8] <= wsh[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Output register read mux; unmapped indices read as zero.
    always_comb begin
        out_rd = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (oidx_q == OW'(k)) begin
                out_rd = out_q[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign io_out_o[32*k +: 32] = out_q[k];
    end

    // Switch inputs pass through one register stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            io_in_q <= '0;
        end else begin
            io_in_q <= io_in_i;
        end
    end

    // Gather source bytes, align them down and extend.
    always_comb begin
        unique case (reg_q)
            REG_DMEM: src = split_q ? {dm_rdata, lo_q}
                                    : {32'h0, dm_rdata};
            REG_OUT:  src = {32'h0, out_rd};
            REG_IN:   src = {32'h0, io_in_q};
            default:  src = '0;
        endcase
        raw    = 32'(src >> {off_q, 3'b000});
        ld_val = ld_ext(raw, size_q, uns_q);
    end

    // Registered one-shot response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rsp_q   <= (state_q == ST_RESP);
            err_q   <= (state_q == ST_RESP) && bad_q;
            rdata_q <= (state_q == ST_RESP && !bad_q && !we_q)
                     ? ld_val : 32'h0;
        end
    end

    assign bus.ready_o     = rdy_q;
    assign bus.rsp_valid_o = rsp_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// lsu_pipe bench.
// Directed vector table plus reset-abort sequence.
module tb_lsu_pipe;

    localparam int NOUT = 11;

    logic               clk;
    logic               rst_n;
    logic [31:0]        io_in;
    logic [NOUT*32-1:0] io_out;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_pipe_if #(.ADDR_W(12)) bus ();

    lsu_pipe #(
        .ADDR_W     (12),
        .DMEM_WORDS (512),
        .NUM_OUT    (NOUT)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .io_in_i  (io_in),
        .io_out_o (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic        we,
        input logic [11:0] addr,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input logic        er,
        input int          lat
    );
        vec_t v;
        v.we = we; v.addr = addr; v.sz = sz; v.uns = uns;
        v.wd = wd; v.rd = rd; v.er = er; v.lat = lat;
        return v;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic xact(input string nm, input vec_t v);
        int w;
        int lat;
        w = 0;
        while (bus.ready_o !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({nm, "_ready"}, {31'h0, bus.ready_o}, 32'h1);
        bus.req_i    = 1'b1;
        bus.we_i     = v.we;
        bus.addr_i   = v.addr;
        bus.size_i   = v.sz;
        bus.unsign_i = v.uns;
        bus.wdata_i  = v.wd;
        @(posedge clk); #1;
        bus.req_i    = 1'b0;
        bus.we_i     = ~v.we;
        bus.addr_i   = ~v.addr;
        bus.size_i   = ~v.sz;
        bus.unsign_i = ~v.uns;
        bus.wdata_i  = ~v.wd;
        chk({nm, "_busy"}, {31'h0, bus.ready_o}, 32'h0);
        lat = 0;
        while (bus.rsp_valid_o !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
        chk({nm, "_rdata"}, bus.rdata_o, v.rd);
        chk({nm, "_err"}, {31'h0, bus.err_o}, {31'h0, v.er});
        @(posedge clk); #1;
        chk({nm, "_oneshot"}, {31'h0, bus.rsp_valid_o}, 32'h0);
    endtask

    task automatic chk_out(input string nm, input int k,
                           input logic [31:0] exp);
        chk($sformatf("%s_out%0d", nm, k), io_out[32*k +: 32], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        io_in        = 32'h0000_0155;
        bus.req_i    = 1'b0;
        bus.we_i     = 1'b0;
        bus.addr_i   = '0;
        bus.size_i   = '0;
        bus.unsign_i = 1'b0;
        bus.wdata_i  = '0;

        tv.push_back(mk(1, 12'h010, 2, 0, 32'hDEADBEEF, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h010, 2, 0, 32'h0, 32'hDEADBEEF, 0, 2));
        tv.push_back(mk(0, 12'h011, 0, 0, 32'h0, 32'hFFFFFFBE, 0, 2));
        tv.push_back(mk(0, 12'h011, 0, 1, 32'h0, 32'h000000BE, 0, 2));
        tv.push_back(mk(0, 12'h012, 1, 0, 32'h0, 32'hFFFFDEAD, 0, 2));
        tv.push_back(mk(0, 12'h012, 1, 1, 32'h0, 32'h0000DEAD, 0, 2));
        tv.push_back(mk(1, 12'h013, 0, 0, 32'h0000005A, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h010, 2, 0, 32'h0, 32'h5AADBEEF, 0, 2));
        tv.push_back(mk(1, 12'h7FE, 2, 0, 32'h11223344, 32'h0, 0, 3));
        tv.push_back(mk(0, 12'h7FE, 2, 0, 32'h0, 32'h11223344, 0, 3));
        tv.push_back(mk(0, 12'h7FF, 1, 0, 32'h0, 32'h00002233, 0, 3));
        tv.push_back(mk(0, 12'h000, 1, 0, 32'h0, 32'h00001122, 0, 2));
        tv.push_back(mk(0, 12'h7FE, 1, 0, 32'h0, 32'h00003344, 0, 2));
        tv.push_back(mk(1, 12'h020, 1, 0, 32'hFFFF8001, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h020, 1, 0, 32'h0, 32'hFFFF8001, 0, 2));
        tv.push_back(mk(0, 12'h020, 1, 1, 32'h0, 32'h00008001, 0, 2));
        tv.push_back(mk(0, 12'h020, 0, 0, 32'h0, 32'h00000001, 0, 2));
        tv.push_back(mk(1, 12'h804, 1, 0, 32'h1234ABCD, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h804, 2, 0, 32'h0, 32'h0000ABCD, 0, 2));
        tv.push_back(mk(1, 12'h82C, 2, 0, 32'hCAFEF00D, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h82C, 2, 0, 32'h0, 32'h00000000, 0, 2));
        tv.push_back(mk(1, 12'h805, 0, 0, 32'h00000080, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h805, 0, 0, 32'h0, 32'hFFFFFF80, 0, 2));
        tv.push_back(mk(0, 12'h804, 2, 0, 32'h0, 32'h000080CD, 0, 2));
        tv.push_back(mk(1, 12'h806, 2, 0, 32'hFFFFFFFF, 32'h0, 1, 2));
        tv.push_back(mk(0, 12'h900, 2, 0, 32'h0, 32'h00000155, 0, 2));
        tv.push_back(mk(0, 12'h901, 0, 0, 32'h0, 32'h00000001, 0, 2));
        tv.push_back(mk(0, 12'h901, 1, 0, 32'h0, 32'h00000000, 1, 2));
        tv.push_back(mk(1, 12'h900, 2, 0, 32'h77777777, 32'h0, 0, 2));
        tv.push_back(mk(0, 12'h010, 3, 0, 32'h0, 32'h00000000, 1, 2));
        tv.push_back(mk(1, 12'h010, 3, 0, 32'h0, 32'h00000000, 1, 2));
        tv.push_back(mk(0, 12'h010, 2, 0, 32'h0, 32'h5AADBEEF, 0, 2));
        tv.push_back(mk(1, 12'h100, 2, 0, 32'h12345678, 32'h0, 0, 2));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.ready_o}, 32'h0);
        chk("rst_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_err", {31'h0, bus.err_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", {31'h0, bus.ready_o}, 32'h1);
        for (int k = 0; k < NOUT; k++) chk_out("rst", k, 32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            xact($sformatf("vec%0d", i), tv[i]);
        end

        for (int k = 0; k < NOUT; k++) begin
            chk_out("map", k, (k == 1) ? 32'h000080CD : 32'h0);
        end

        bus.req_i    = 1'b1;
        bus.we_i     = 1'b1;
        bus.addr_i   = 12'h0FE;
        bus.size_i   = 2'b10;
        bus.unsign_i = 1'b0;
        bus.wdata_i  = 32'hAAAAAAAA;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", {31'h0, bus.ready_o}, 32'h0);
        chk("abort_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready", {31'h0, bus.ready_o}, 32'h1);
        chk("abort_rel_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
        for (int k = 0; k < NOUT; k++) chk_out("abort", k, 32'h0);
        xact("abort_hi_word",
             mk(0, 12'h100, 2, 0, 32'h0, 32'h12345678, 0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
